// File: rtl/io_input_conditioner_pkg.sv
// Shared constants for the DE10-Lite key/switch input conditioner.
package io_cond_pkg;

    localparam int NUM_KEYS_DEF = 4;
    localparam int NUM_SW_DEF   = 10;

    // 10 ms at 50 MHz for hardware; a short window keeps simulation fast.
    localparam int DEBOUNCE_DEF = 500000;
    localparam int DEBOUNCE_SIM = 4;

    // Levels the channels assume at reset: keys are active-low (released = 1),
    // switches read 0 until the first debounced sample says otherwise.
    localparam logic KEY_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Raw board inputs plus the conditioned levels and event pulses.
// master = board/testbench side, slave = conditioner side.
interface io_input_conditioner_if #(
    parameter int NUM_KEYS = io_cond_pkg::NUM_KEYS_DEF,
    parameter int NUM_SW   = io_cond_pkg::NUM_SW_DEF
);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_SW-1:0]   sw_raw;
    logic [NUM_KEYS-1:0] key_db;
    logic [NUM_SW-1:0]   sw_db;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_SW-1:0]   sw_change;

    modport master (
        output key_raw, sw_raw,
        input  key_db, sw_db, key_press, key_release, sw_change
    );

    modport slave (
        input  key_raw, sw_raw,
        output key_db, sw_db, key_press, key_release, sw_change
    );

endinterface

// File: rtl/io_input_conditioner_debounce.sv
// One input channel: 2-flop synchroniser, stability counter, accepted level
// and registered rise/fall pulses that coincide with the level update.
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter logic IDLE_LEVEL      = SW_IDLE,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             d_q, d_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] c_q, c_d;

    // Any cycle where the synced level agrees with the accepted level throws
    // away the accumulated count, so only an unbroken run is accepted.
    always_comb begin
        d_d    = d_q;
        c_d    = c_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == d_q) begin
            c_d = '0;
        end else if (c_q == CNT_LAST) begin
            d_d    = s2_q;
            c_d    = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            c_d = c_q + CNT_W'(1);
        end
    end

    // Synchroniser, debounce state and pulse registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_q   <= IDLE_LEVEL;
            s2_q   <= IDLE_LEVEL;
            d_q    <= IDLE_LEVEL;
            c_q    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            d_q    <= d_d;
            c_q    <= c_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = d_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces KEY[3:0] and SW[9:0] ahead of the Nios PIOs and
// produces press/release/change pulses for fabric consumers.
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int NUM_SW          = NUM_SW_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    io_input_conditioner_if.slave   io
);

    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    // Keys are active-low: a falling accepted level is a press.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (KEY_IDLE),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk_clk     (clk_clk),
            .reset_reset (reset_reset),
            .raw_i       (io.key_raw[i]),
            .level_o     (io.key_db[i]),
            .rise_o      (io.key_release[i]),
            .fall_o      (io.key_press[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (SW_IDLE),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk_clk     (clk_clk),
            .reset_reset (reset_reset),
            .raw_i       (io.sw_raw[i]),
            .level_o     (io.sw_db[i]),
            .rise_o      (sw_rise[i]),
            .fall_o      (sw_fall[i])
        );
    end

    // Both pulse sources are registered, so the OR adds no input-to-output path.
    assign io.sw_change = sw_rise | sw_fall;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with a 4-cycle debounce window.
module tb_io_input_conditioner;
    import io_cond_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [9:0] chg;
        logic [3:0] kdb;
        logic [9:0] sdb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_seen = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [3:0] cur_k = 4'hF;
    logic [9:0] cur_s = 10'h000;

    io_input_conditioner_if #(.NUM_KEYS(4), .NUM_SW(10)) bus ();

    io_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_SIM)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .io          (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h (kdb,sdb,press,rel,chg)", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [9:0] ch, input logic [3:0] kd, input logic [9:0] sd);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.chg = ch; e.kdb = kd; e.sdb = sd;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every cycle against either the queued event or the
    // steady state implied by the last accepted event.
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t e;
        act = {bus.key_db, bus.sw_db, bus.key_press, bus.key_release, bus.sw_change};
        if (rst_seen) begin
            cur_k = 4'hF;
            cur_s = 10'h000;
            cmp("reset_state", act, {4'hF, 10'h000, 4'h0, 4'h0, 10'h000});
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            cmp("event", act, {e.kdb, e.sdb, e.press, e.rel, e.chg});
            cur_k = e.kdb;
            cur_s = e.sdb;
        end else begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d got=none expected_at=%0d", cyc, e.cyc);
            end
            cmp("steady", act, {cur_k, cur_s, 4'h0, 4'h0, 10'h000});
        end
    end

    initial begin
        bus.key_raw = 4'($urandom);
        bus.sw_raw  = 10'($urandom);
        rst = 1'b1;
        step(1);
        bus.key_raw = 4'($urandom);
        bus.sw_raw  = 10'($urandom);
        step(2);
        rst = 1'b0;
        bus.key_raw = 4'hF;
        bus.sw_raw  = 10'h000;
        step(3);

        // clean press
        bus.key_raw[0] = 1'b0;
        push(cyc + 6, 4'b0001, 4'b0000, 10'h000, 4'b1110, 10'h000);
        step(10);

        // bounce: 3 low, 1 high, then low held
        bus.key_raw[1] = 1'b0;
        step(3);
        bus.key_raw[1] = 1'b1;
        step(1);
        bus.key_raw[1] = 1'b0;
        push(cyc + 6, 4'b0010, 4'b0000, 10'h000, 4'b1100, 10'h000);
        step(12);

        // 3-cycle switch glitch must be rejected
        bus.sw_raw[3] = 1'b1;
        step(3);
        bus.sw_raw[3] = 1'b0;
        step(10);

        // simultaneous key and switch
        bus.key_raw[2] = 1'b0;
        bus.sw_raw[9]  = 1'b1;
        push(cyc + 6, 4'b0100, 4'b0000, 10'h200, 4'b1000, 10'h200);
        step(10);

        // reset on edge 4 of a key3 press; afterwards every held input is re-accepted
        bus.key_raw[3] = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push(cyc + 6, 4'b1111, 4'b0000, 10'h200, 4'b0000, 10'h200);
        step(10);

        // key release
        bus.key_raw[0] = 1'b1;
        push(cyc + 6, 4'b0000, 4'b0001, 10'h000, 4'b0001, 10'h200);
        step(10);

        // switch back down
        bus.sw_raw[9] = 1'b0;
        push(cyc + 6, 4'b0000, 4'b0000, 10'h200, 4'b0001, 10'h000);
        step(10);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
